// File: rtl/wb_dcache_ctrl_if.sv
// Handshake bundle between the write-back dcache controller and the
// LSU/MMU, the dcache datapath and the memory bus interface.
interface wb_dcache_ctrl_if #(
  parameter int IDX_BITS = 8
);
  logic                lsu_req_i;
  logic                lsu_we_i;
  logic                lsu_ack_o;
  logic                lsu_busy_o;
  logic                dcache_flush_i;
  logic                flush_done_o;
  logic                array_req_o;
  logic                cache_hit_i;
  logic                cache_evict_req_i;
  logic                dcache_valid_i;
  logic                victim_hit_i;
  logic                cache_wr_o;
  logic                cache_line_wr_o;
  logic                cache_line_clean_o;
  logic                cache_wrb_req_o;
  logic                write_to_victim_o;
  logic                write_from_victim_o;
  logic                lsu_victim_mux_sel_o;
  logic [IDX_BITS-1:0] evict_index_o;
  logic                mem_req_o;
  logic                mem_wr_o;
  logic                mem_ack_i;

  modport master (
    input  lsu_req_i, lsu_we_i, dcache_flush_i,
    input  cache_hit_i, cache_evict_req_i,
    input  dcache_valid_i, victim_hit_i, mem_ack_i,
    output lsu_ack_o, lsu_busy_o, flush_done_o,
    output array_req_o, cache_wr_o, cache_line_wr_o,
    output cache_line_clean_o, cache_wrb_req_o,
    output write_to_victim_o, write_from_victim_o,
    output lsu_victim_mux_sel_o, evict_index_o,
    output mem_req_o, mem_wr_o
  );

  modport slave (
    output lsu_req_i, lsu_we_i, dcache_flush_i,
    output cache_hit_i, cache_evict_req_i,
    output dcache_valid_i, victim_hit_i, mem_ack_i,
    input  lsu_ack_o, lsu_busy_o, flush_done_o,
    input  array_req_o, cache_wr_o, cache_line_wr_o,
    input  cache_line_clean_o, cache_wrb_req_o,
    input  write_to_victim_o, write_from_victim_o,
    input  lsu_victim_mux_sel_o, evict_index_o,
    input  mem_req_o, mem_wr_o
  );
endinterface

// File: rtl/wb_dcache_ctrl.sv
// Sequencing FSM for the write-back dcache with victim cache:
// lookup, victim swap, write-back, refill and full-index flush walk.
module wb_dcache_ctrl #(
  parameter int IDX_BITS = 8
) (
  input logic              clk,
  input logic              rst_n,
  wb_dcache_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    CMP,
    VSWAP,
    WB,
    ALLOC,
    RERD,
    FL_RD,
    FL_CHK,
    FL_WB,
    FL_NXT
  } state_t;

  localparam logic [IDX_BITS-1:0] IDX_ONE  = 1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  state_t              state;
  state_t              state_nxt;
  logic                flush_pending;
  logic                flush_pending_nxt;
  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS-1:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      idx           <= '0;
    end else begin
      state         <= state_nxt;
      flush_pending <= flush_pending_nxt;
      idx           <= idx_nxt;
    end
  end

  assign bus.evict_index_o = idx;
  assign bus.lsu_busy_o    = (state != IDLE);

  always_comb begin
    state_nxt                = state;
    idx_nxt                  = idx;
    flush_pending_nxt        = flush_pending;
    bus.lsu_ack_o            = 1'b0;
    bus.flush_done_o         = 1'b0;
    bus.array_req_o          = 1'b0;
    bus.cache_wr_o           = 1'b0;
    bus.cache_line_wr_o      = 1'b0;
    bus.cache_line_clean_o   = 1'b0;
    bus.cache_wrb_req_o      = 1'b0;
    bus.write_to_victim_o    = 1'b0;
    bus.write_from_victim_o  = 1'b0;
    bus.lsu_victim_mux_sel_o = 1'b0;
    bus.mem_req_o            = 1'b0;
    bus.mem_wr_o             = 1'b0;

    // a flush seen mid-transaction waits for the return to IDLE
    if (bus.dcache_flush_i && state != IDLE)
      flush_pending_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (bus.dcache_flush_i || flush_pending) begin
          flush_pending_nxt = 1'b0;
          idx_nxt           = '0;
          state_nxt         = FL_RD;
        end else if (bus.lsu_req_i) begin
          bus.array_req_o = 1'b1;
          state_nxt       = CMP;
        end
      end
      CMP: begin
        if (bus.cache_hit_i) begin
          bus.lsu_ack_o   = 1'b1;
          bus.cache_wr_o  = bus.lsu_we_i;
          bus.array_req_o = bus.lsu_we_i;
          state_nxt       = IDLE;
        end else if (bus.victim_hit_i) begin
          state_nxt = VSWAP;
        end else if (bus.cache_evict_req_i) begin
          state_nxt = WB;
        end else begin
          bus.write_to_victim_o = bus.dcache_valid_i;
          state_nxt             = ALLOC;
        end
      end
      VSWAP: begin
        bus.write_from_victim_o = 1'b1;
        bus.write_to_victim_o   = bus.dcache_valid_i;
        bus.array_req_o         = 1'b1;
        if (!bus.lsu_we_i) begin
          bus.lsu_victim_mux_sel_o = 1'b1;
          bus.lsu_ack_o            = 1'b1;
          state_nxt                = IDLE;
        end else begin
          state_nxt = RERD;
        end
      end
      WB: begin
        bus.cache_wrb_req_o = 1'b1;
        bus.mem_req_o       = 1'b1;
        bus.mem_wr_o        = 1'b1;
        if (bus.mem_ack_i)
          state_nxt = ALLOC;
      end
      ALLOC: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_ack_i) begin
          bus.cache_line_wr_o = 1'b1;
          bus.array_req_o     = 1'b1;
          state_nxt           = RERD;
        end
      end
      RERD: begin
        bus.array_req_o = 1'b1;
        state_nxt       = CMP;
      end
      FL_RD: begin
        bus.array_req_o = 1'b1;
        state_nxt       = FL_CHK;
      end
      FL_CHK: begin
        state_nxt = bus.cache_evict_req_i ? FL_WB : FL_NXT;
      end
      FL_WB: begin
        bus.cache_wrb_req_o = 1'b1;
        bus.mem_req_o       = 1'b1;
        bus.mem_wr_o        = 1'b1;
        if (bus.mem_ack_i) begin
          bus.cache_line_clean_o = 1'b1;
          bus.array_req_o        = 1'b1;
          state_nxt              = FL_NXT;
        end
      end
      FL_NXT: begin
        if (idx == IDX_LAST) begin
          bus.flush_done_o = 1'b1;
          idx_nxt          = '0;
          state_nxt        = IDLE;
        end else begin
          idx_nxt   = idx + IDX_ONE;
          state_nxt = FL_RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_dcache_ctrl.sv
// Directed vector bench for wb_dcache_ctrl (IDX_BITS=2): one row
// per cycle, plus a flush-walk and a refill-latency sequence.
module tb_wb_dcache_ctrl;

  localparam int IB = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_dcache_ctrl_if #(.IDX_BITS(IB)) bus ();

  wb_dcache_ctrl #(.IDX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [8:0] I_RST = 9'h100;
  localparam logic [8:0] I_REQ = 9'h080;
  localparam logic [8:0] I_WE  = 9'h040;
  localparam logic [8:0] I_FL  = 9'h020;
  localparam logic [8:0] I_HIT = 9'h010;
  localparam logic [8:0] I_EV  = 9'h008;
  localparam logic [8:0] I_VLD = 9'h004;
  localparam logic [8:0] I_VH  = 9'h002;
  localparam logic [8:0] I_ACK = 9'h001;

  localparam logic [12:0] O_ACK = 13'h1000;
  localparam logic [12:0] O_BSY = 13'h0800;
  localparam logic [12:0] O_DN  = 13'h0400;
  localparam logic [12:0] O_ARQ = 13'h0200;
  localparam logic [12:0] O_WR  = 13'h0100;
  localparam logic [12:0] O_LWR = 13'h0080;
  localparam logic [12:0] O_CLN = 13'h0040;
  localparam logic [12:0] O_WRB = 13'h0020;
  localparam logic [12:0] O_TOV = 13'h0010;
  localparam logic [12:0] O_FRV = 13'h0008;
  localparam logic [12:0] O_VSL = 13'h0004;
  localparam logic [12:0] O_MRQ = 13'h0002;
  localparam logic [12:0] O_MWR = 13'h0001;

  localparam logic [12:0] O_FWB = O_BSY | O_WRB | O_MRQ | O_MWR;
  localparam logic [12:0] O_REF = O_BSY | O_MRQ | O_LWR | O_ARQ;

  typedef struct {
    string          name;
    logic [8:0]     in;
    logic [12:0]    exp;
    logic [IB-1:0]  idx;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string n, input logic [8:0] i,
                     input logic [12:0] o, input logic [IB-1:0] x);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = o;
    v.idx  = x;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [8:0] i);
    rst_n                 = ~i[8];
    bus.lsu_req_i         = i[7];
    bus.lsu_we_i          = i[6];
    bus.dcache_flush_i    = i[5];
    bus.cache_hit_i       = i[4];
    bus.cache_evict_req_i = i[3];
    bus.dcache_valid_i    = i[2];
    bus.victim_hit_i      = i[1];
    bus.mem_ack_i         = i[0];
  endtask

  function automatic logic [12:0] outs();
    return {bus.lsu_ack_o, bus.lsu_busy_o, bus.flush_done_o,
            bus.array_req_o, bus.cache_wr_o, bus.cache_line_wr_o,
            bus.cache_line_clean_o, bus.cache_wrb_req_o,
            bus.write_to_victim_o, bus.write_from_victim_o,
            bus.lsu_victim_mux_sel_o, bus.mem_req_o, bus.mem_wr_o};
  endfunction

  task automatic check(input string n, input logic [12:0] o,
                       input logic [IB-1:0] x);
    logic [12:0] got;
    got = outs();
    n_vec++;
    if (got !== o || bus.evict_index_o !== x) begin
      n_bad++;
      $display("FAIL %s: got out=%b idx=%0d, expected out=%b idx=%0d",
               n, got, bus.evict_index_o, o, x);
    end
  endtask

  initial begin
    int          done_at;
    int          ack_at;
    int          mem_cnt;
    logic        refilled;
    logic [8:0]  in;
    localparam int L = 4;

    drive(I_RST);
    repeat (2) @(posedge clk);

    // load hit, store hit
    add("ld_idle",   I_REQ,                 O_ARQ,                     0);
    add("ld_hit",    I_REQ|I_HIT,           O_BSY|O_ACK,               0);
    add("idle0",     9'h000,                13'h0,                     0);
    add("st_idle",   I_REQ|I_WE,            O_ARQ,                     0);
    add("st_hit",    I_REQ|I_WE|I_HIT,      O_BSY|O_ACK|O_WR|O_ARQ,    0);
    add("idle1",     9'h000,                13'h0,                     0);
    // dirty miss, 3-cycle write-back then 3-cycle refill
    add("dm_idle",   I_REQ,                 O_ARQ,                     0);
    add("dm_cmp",    I_REQ|I_EV|I_VLD,      O_BSY,                     0);
    add("dm_wb1",    I_REQ,                 O_FWB,                     0);
    add("dm_wb2",    I_REQ,                 O_FWB,                     0);
    add("dm_wb3",    I_REQ|I_ACK,           O_FWB,                     0);
    add("dm_rd1",    I_REQ,                 O_BSY|O_MRQ,               0);
    add("dm_rd2",    I_REQ,                 O_BSY|O_MRQ,               0);
    add("dm_rd3",    I_REQ|I_ACK,           O_REF,                     0);
    add("dm_rerd",   I_REQ,                 O_BSY|O_ARQ,               0);
    add("dm_hit",    I_REQ|I_HIT,           O_BSY|O_ACK,               0);
    add("idle2",     9'h000,                13'h0,                     0);
    // clean valid miss, store: line goes to victim
    add("cm_idle",   I_REQ|I_WE,            O_ARQ,                     0);
    add("cm_cmp",    I_REQ|I_WE|I_VLD,      O_BSY|O_TOV,               0);
    add("cm_alloc",  I_REQ|I_WE|I_ACK,      O_REF,                     0);
    add("cm_rerd",   I_REQ|I_WE,            O_BSY|O_ARQ,               0);
    add("cm_hit",    I_REQ|I_WE|I_HIT,      O_BSY|O_ACK|O_WR|O_ARQ,    0);
    // invalid line miss, load
    add("im_idle",   I_REQ,                 O_ARQ,                     0);
    add("im_cmp",    I_REQ,                 O_BSY,                     0);
    add("im_alloc",  I_REQ|I_ACK,           O_REF,                     0);
    add("im_rerd",   I_REQ,                 O_BSY|O_ARQ,               0);
    add("im_hit",    I_REQ|I_HIT,           O_BSY|O_ACK,               0);
    // victim load hit beats a dirty line
    add("vl_idle",   I_REQ,                 O_ARQ,                     0);
    add("vl_cmp",    I_REQ|I_VH|I_VLD|I_EV, O_BSY,                     0);
    add("vl_swap",   I_REQ|I_VLD,
        O_BSY|O_FRV|O_TOV|O_ARQ|O_VSL|O_ACK,                            0);
    add("idle3",     9'h000,                13'h0,                     0);
    // victim store hit, invalid line
    add("vs_idle",   I_REQ|I_WE,            O_ARQ,                     0);
    add("vs_cmp",    I_REQ|I_WE|I_VH,       O_BSY,                     0);
    add("vs_swap",   I_REQ|I_WE,            O_BSY|O_FRV|O_ARQ,         0);
    add("vs_rerd",   I_REQ|I_WE,            O_BSY|O_ARQ,               0);
    add("vs_hit",    I_REQ|I_WE|I_HIT,      O_BSY|O_ACK|O_WR|O_ARQ,    0);
    add("stray_ack", I_ACK,                 13'h0,                     0);
    // flush pulsed mid-miss, then walk with lines 1 and 3 dirty
    add("df_idle",   I_REQ,                 O_ARQ,                     0);
    add("df_cmp",    I_REQ,                 O_BSY,                     0);
    add("df_fl",     I_REQ|I_FL,            O_BSY|O_MRQ,               0);
    add("df_alloc",  I_REQ|I_ACK,           O_REF,                     0);
    add("df_rerd",   I_REQ,                 O_BSY|O_ARQ,               0);
    add("df_hit",    I_REQ|I_HIT,           O_BSY|O_ACK,               0);
    add("df_prio",   I_REQ,                 13'h0,                     0);
    add("fl_rd0",    9'h000,                O_BSY|O_ARQ,               0);
    add("fl_chk0",   9'h000,                O_BSY,                     0);
    add("fl_nxt0",   9'h000,                O_BSY,                     0);
    add("fl_rd1",    9'h000,                O_BSY|O_ARQ,               1);
    add("fl_chk1",   I_EV,                  O_BSY,                     1);
    add("fl_wb1a",   9'h000,                O_FWB,                     1);
    add("fl_wb1b",   I_ACK,                 O_FWB|O_CLN|O_ARQ,         1);
    add("fl_nxt1",   9'h000,                O_BSY,                     1);
    add("fl_rd2",    9'h000,                O_BSY|O_ARQ,               2);
    add("fl_chk2",   9'h000,                O_BSY,                     2);
    add("fl_nxt2",   9'h000,                O_BSY,                     2);
    add("fl_rd3",    9'h000,                O_BSY|O_ARQ,               3);
    add("fl_chk3",   I_EV,                  O_BSY,                     3);
    add("fl_wb3",    I_ACK,                 O_FWB|O_CLN|O_ARQ,         3);
    add("fl_nxt3",   9'h000,                O_BSY|O_DN,                3);
    add("fl_end",    9'h000,                13'h0,                     0);
    // reset during refill wait, then a normal load
    add("rs_idle",   I_REQ,                 O_ARQ,                     0);
    add("rs_cmp",    I_REQ,                 O_BSY,                     0);
    add("rs_alloc",  I_REQ,                 O_BSY|O_MRQ,               0);
    add("rs_assert", I_RST,                 O_BSY|O_MRQ,               0);
    add("rs_after",  9'h000,                13'h0,                     0);
    add("rs_ack",    I_ACK,                 13'h0,                     0);
    add("rs_ld",     I_REQ,                 O_ARQ,                     0);
    add("rs_hit",    I_REQ|I_HIT,           O_BSY|O_ACK,               0);
    add("rs_end",    9'h000,                13'h0,                     0);

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].in);
      #1;
      check(vq[k].name, vq[k].exp, vq[k].idx);
    end

    // flush from IDLE, no dirty lines: done on the 12th cycle
    @(negedge clk);
    drive(I_FL);
    #1;
    check("fw_start", 13'h0, 0);
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge clk);
      drive(9'h000);
      #1;
      if (bus.flush_done_o === 1'b1) begin
        done_at = c;
        check("fw_done", O_BSY|O_DN, 3);
      end
    end
    n_vec++;
    if (done_at != 12) begin
      n_bad++;
      $display("FAIL fw_latency: done at cycle %0d, expected 12", done_at);
    end
    @(negedge clk);
    drive(9'h000);
    #1;
    check("fw_idle", 13'h0, 0);

    // clean miss with memory latency L: ack on cycle L+5
    ack_at   = 0;
    mem_cnt  = 0;
    refilled = 1'b0;
    for (int c = 1; c <= 40 && ack_at == 0; c++) begin
      @(negedge clk);
      in = I_REQ | (refilled ? I_HIT : 9'h000);
      drive(in);
      #1;
      if (bus.mem_req_o === 1'b1) begin
        if (mem_cnt == L) begin
          bus.mem_ack_i = 1'b1;
          refilled      = 1'b1;
        end
        mem_cnt++;
      end
      #1;
      if (bus.lsu_ack_o === 1'b1)
        ack_at = c;
    end
    n_vec++;
    if (ack_at != L + 5) begin
      n_bad++;
      $display("FAIL miss_latency: ack at cycle %0d, expected %0d",
               ack_at, L + 5);
    end
    n_vec++;
    if (mem_cnt != L + 1) begin
      n_bad++;
      $display("FAIL miss_memreq: mem_req cycles %0d, expected %0d",
               mem_cnt, L + 1);
    end
    @(negedge clk);
    drive(9'h000);
    #1;
    check("lat_idle", 13'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
